// File: rtl/icache_refill_port.sv
`default_nettype none
// ============================================================================
// Module   : icache_refill_port
// Purpose  : Memory-side responder for the instruction-cache line refill
//            interface. Each refill request becomes one AXI4 INCR burst of
//            LINE_WORDS 32-bit beats. The beats are assembled into a cache
//            line, which is returned with a single-cycle ret_valid pulse.
// Ports    : clk, reset (async, active-low)
//            rd_req / rd_addr       - refill request from the icache
//            ret_valid / ret_data   - returned line, word i at [32i+31:32i]
//            ar*                    - AXI read address channel (master side)
//            r*                     - AXI read data channel (master side)
//            bus_err                - sticky error flag, cleared by reset only
// Options  : `define ICACHE_REFILL_LINE_BUF_EN keeps the tag of the last
//            good line. A repeat request for that line is then answered
//            from ret_data without any AXI traffic.
// Revision : 1.0 - initial release
// ============================================================================
module icache_refill_port #(
   parameter int         LINE_WORDS = 8,
   parameter logic [3:0] ARID_VAL   = 4'h0,
   parameter int         OFFSET_W   = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     rd_req,
   input  logic [31:0]              rd_addr,
   output logic                     ret_valid,
   output logic [32*LINE_WORDS-1:0] ret_data,
   output logic                     arvalid,
   input  logic                     arready,
   output logic [31:0]              araddr,
   output logic [7:0]               arlen,
   output logic [2:0]               arsize,
   output logic [1:0]               arburst,
   output logic [3:0]               arid,
   input  logic                     rvalid,
   output logic                     rready,
   input  logic [31:0]              rdata,
   input  logic [1:0]               rresp,
   input  logic                     rlast,
   input  logic [3:0]               rid,
   output logic                     bus_err
);

   localparam int                 c_CNT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(LINE_WORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_AR    = 3'd1,
      S_R     = 3'd2,
      S_RESP  = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   state_t                    state_q;
   logic                      arvalid_q;
   logic                      rready_q;
   logic                      ret_valid_q;
   logic                      bus_err_q;
   logic [31:0]               araddr_q;
   logic [c_CNT_W-1:0]        cnt_q;
   logic [32*LINE_WORDS-1:0]  line_q;
   logic [32*LINE_WORDS-1:0]  ret_data_q;

   logic [32*LINE_WORDS-1:0]  w_line_d;
   logic [31:0]               w_line_addr;
   logic                      w_beat;
   logic                      w_last;
   logic                      w_beat_err;
   logic                      w_hit;

   // Byte-offset bits of rd_addr are dropped by line alignment.
   logic                      w_unused_offset;
   assign w_unused_offset = ^rd_addr[OFFSET_W-1:0];

   assign w_line_addr = {rd_addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
   assign w_beat      = (state_q == S_R) && rvalid && rready_q;
   assign w_last      = (cnt_q == c_LAST);

   // The final beat must carry rlast, and no earlier beat may carry it.
   assign w_beat_err  = (rresp != 2'b00) || (rid != ARID_VAL) ||
                        (w_last ? !rlast : rlast);

   // Line with the current beat merged into slot cnt_q. On the final beat
   // this value goes straight to ret_data, so ret_data only changes when a
   // whole line is complete.
   for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_word
      assign w_line_d[32*gi +: 32] = (cnt_q == c_CNT_W'(gi)) ? rdata
                                                            : line_q[32*gi +: 32];
   end

`ifdef ICACHE_REFILL_LINE_BUF_EN
   logic [31-OFFSET_W:0] tag_q;
   logic                 tag_vld_q;
   logic                 burst_err_q;

   // Tag of the most recent line returned without error. Any error in a
   // burst invalidates the entry, because ret_data then holds a suspect line.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tag_q       <= '0;
         tag_vld_q   <= 1'b0;
         burst_err_q <= 1'b0;
      end else begin
         if ((state_q == S_IDLE) && rd_req && !w_hit) begin
            burst_err_q <= 1'b0;
         end else if (w_beat && w_beat_err) begin
            burst_err_q <= 1'b1;
         end
         if (w_beat && w_last) begin
            tag_vld_q <= !(burst_err_q || w_beat_err);
            tag_q     <= araddr_q[31:OFFSET_W];
         end
      end
   end

   assign w_hit = tag_vld_q && (rd_addr[31:OFFSET_W] == tag_q);
`else
   assign w_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         ret_valid_q <= 1'b0;
         bus_err_q   <= 1'b0;
         araddr_q    <= '0;
         cnt_q       <= '0;
         line_q      <= '0;
         ret_data_q  <= '0;
      end else begin
         ret_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (rd_req) begin
                  if (w_hit) begin
                     // Requested line is already on ret_data.
                     ret_valid_q <= 1'b1;
                     state_q     <= S_RESP;
                  end else begin
                     araddr_q    <= w_line_addr;
                     arvalid_q   <= 1'b1;
                     state_q     <= S_AR;
                  end
               end
            end
            S_AR: begin
               if (arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  cnt_q     <= '0;
                  state_q   <= S_R;
               end
            end
            S_R: begin
               if (w_beat) begin
                  line_q <= w_line_d;
                  cnt_q  <= cnt_q + c_CNT_W'(1);
                  if (w_beat_err) begin
                     bus_err_q <= 1'b1;
                  end
                  // The burst always ends on the LINE_WORDS-th beat, whatever rlast says.
                  if (w_last) begin
                     rready_q    <= 1'b0;
                     ret_data_q  <= w_line_d;
                     ret_valid_q <= 1'b1;
                     state_q     <= S_RESP;
                  end
               end
            end
            S_RESP: begin
               state_q <= S_DRAIN;
            end
            S_DRAIN: begin
               // Absorbs the icache's one-cycle lag in dropping rd_req.
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign ret_valid = ret_valid_q;
   assign ret_data  = ret_data_q;
   assign arvalid   = arvalid_q;
   assign araddr    = araddr_q;
   assign arlen     = 8'(LINE_WORDS - 1);
   assign arsize    = 3'b010;
   assign arburst   = 2'b01;
   assign arid      = ARID_VAL;
   assign rready    = rready_q;
   assign bus_err   = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_icache_refill_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_refill_port
// Purpose  : Directed self-checking bench for icache_refill_port (LINE_WORDS=8).
//            The bench plays the AXI slave and the icache.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache_refill_port;

   localparam int LW = 8;
   localparam int DW = 32 * LW;

   logic          clk = 1'b0;
   logic          reset;
   logic          rd_req;
   logic [31:0]   rd_addr;
   logic          ret_valid;
   logic [DW-1:0] ret_data;
   logic          arvalid;
   logic          arready;
   logic [31:0]   araddr;
   logic [7:0]    arlen;
   logic [2:0]    arsize;
   logic [1:0]    arburst;
   logic [3:0]    arid;
   logic          rvalid;
   logic          rready;
   logic [31:0]   rdata;
   logic [1:0]    rresp;
   logic          rlast;
   logic [3:0]    rid;
   logic          bus_err;

   icache_refill_port #(
      .LINE_WORDS (LW),
      .ARID_VAL   (4'h0),
      .OFFSET_W   (5)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rd_req    (rd_req),
      .rd_addr   (rd_addr),
      .ret_valid (ret_valid),
      .ret_data  (ret_data),
      .arvalid   (arvalid),
      .arready   (arready),
      .araddr    (araddr),
      .arlen     (arlen),
      .arsize    (arsize),
      .arburst   (arburst),
      .arid      (arid),
      .rvalid    (rvalid),
      .rready    (rready),
      .rdata     (rdata),
      .rresp     (rresp),
      .rlast     (rlast),
      .rid       (rid),
      .bus_err   (bus_err)
   );

   always #5 clk = ~clk;

   int   vectors     = 0;
   int   miscompares = 0;
   int   cyc         = 0;
   int   rv_cnt      = 0;
   int   rv_cyc      = 0;
   int   ar_cnt      = 0;
   int   beats       = 0;
   logic arv_prev    = 1'b0;
   int   req_cyc, rv_base, ar_base, beat_base;

   // Event monitors: accepted R beats at the edge, outputs 1 time unit later.
   always @(posedge clk) begin
      cyc++;
      if (rvalid === 1'b1 && rready === 1'b1) beats++;
      #1;
      if (ret_valid === 1'b1) begin
         rv_cnt++;
         rv_cyc = cyc;
      end
      if (arvalid === 1'b1 && arv_prev !== 1'b1) ar_cnt++;
      arv_prev = arvalid;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end of test, expected completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] mk_line(input logic [31:0] base);
      logic [DW-1:0] l;
      for (int i = 0; i < LW; i++) l[32*i +: 32] = base + 32'(i);
      return l;
   endfunction

   // Raise rd_req at the current falling edge; the DUT is expected in IDLE.
   task automatic start_req(input logic [31:0] addr);
      rd_req    = 1'b1;
      rd_addr   = addr;
      req_cyc   = cyc;
      rv_base   = rv_cnt;
      ar_base   = ar_cnt;
      beat_base = beats;
   endtask

   task automatic request(input logic [31:0] addr);
      @(negedge clk);
      start_req(addr);
      @(negedge clk);
      rd_req = 1'b0;
   endtask

   // Slave side of one full burst, entered with the DUT in AR. Returns at
   // the falling edge where ret_valid should be high.
   task automatic serve(input logic [31:0] exp_addr, input int ar_wait, input bit sparse,
                        input int err_beat, input int early_last, input logic [31:0] dbase);
      int i;
      int slot;
      check("ar_count", 32'(ar_cnt), 32'(ar_base + 1));
      check("arvalid", arvalid, 1'b1);
      check("araddr", araddr, exp_addr);
      check("rready_in_ar", rready, 1'b0);
      for (int k = 0; k < ar_wait; k++) begin
         @(negedge clk);
         check("arvalid_hold", arvalid, 1'b1);
         check("araddr_hold", araddr, exp_addr);
      end
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      check("arvalid_done", arvalid, 1'b0);
      check("rready_in_r", rready, 1'b1);
      i    = 0;
      slot = 0;
      while (i < LW) begin
         rvalid = sparse ? (slot % 3 == 0) : 1'b1;
         rdata  = dbase + 32'(i);
         rresp  = (i == err_beat) ? 2'b10 : 2'b00;
         rlast  = (i == LW - 1) || (i == early_last);
         if (rvalid && i == err_beat) check("bus_err_before", bus_err, 1'b0);
         @(negedge clk);
         if (rvalid) begin
            if (i == err_beat) check("bus_err_after", bus_err, 1'b1);
            i++;
         end
         slot++;
      end
      rvalid = 1'b0;
      rlast  = 1'b0;
      rresp  = 2'b00;
   endtask

   // Checks the returned line, then steps into DRAIN.
   task automatic post_line(input logic [DW-1:0] exp_line, input bit exp_err, input int exp_lat);
      check("ret_valid", ret_valid, 1'b1);
      check("latency", 32'(rv_cyc - req_cyc), 32'(exp_lat));
      check("ret_data", ret_data, exp_line);
      check("bus_err", bus_err, exp_err);
      check("beats", 32'(beats - beat_base), 32'(LW));
      @(negedge clk);
      check("ret_valid_pulse", ret_valid, 1'b0);
      check("ret_count", 32'(rv_cnt - rv_base), 32'd1);
      check("arvalid_drain", arvalid, 1'b0);
   endtask

   initial begin
      int b0;
      reset   = 1'b1;
      rd_req  = 1'b0;
      rd_addr = '0;
      arready = 1'b0;
      rvalid  = 1'b0;
      rdata   = '0;
      rresp   = 2'b00;
      rlast   = 1'b0;
      rid     = 4'h0;
      #1 reset = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_arvalid", arvalid, 1'b0);
      check("rst_rready", rready, 1'b0);
      check("rst_ret_valid", ret_valid, 1'b0);
      check("rst_bus_err", bus_err, 1'b0);
      check("rst_ret_data", ret_data, '0);
      check("rst_araddr", araddr, 32'h0);
      check("arlen", arlen, 8'd7);
      check("arsize", arsize, 3'd2);
      check("arburst", arburst, 2'd1);
      check("arid", arid, 4'h0);
      @(negedge clk);
      reset = 1'b1;

      // Basic line fetch
      request(32'h1C00_0044);
      serve(32'h1C00_0040, 0, 1'b0, -1, -1, 32'hA0);
      post_line(mk_line(32'hA0), 1'b0, 10);

      // Backpressure on AR and R
      request(32'h1C00_0080);
      serve(32'h1C00_0080, 5, 1'b1, -1, -1, 32'hA0);
      post_line(mk_line(32'hA0), 1'b0, 29);

      // Error response on beat 3
      request(32'h1C00_0100);
      serve(32'h1C00_0100, 0, 1'b0, 3, -1, 32'h300);
      post_line(mk_line(32'h300), 1'b1, 10);

      // Reset mid-burst, after beat 4
      request(32'h3000_0000);
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         rvalid = 1'b1;
         rdata  = 32'h400 + 32'(i);
         @(negedge clk);
      end
      rdata = 32'hDEAD_BEEF;
      reset = 1'b0;
      #1;
      check("mid_rst_arvalid", arvalid, 1'b0);
      check("mid_rst_rready", rready, 1'b0);
      check("mid_rst_ret_valid", ret_valid, 1'b0);
      check("mid_rst_bus_err", bus_err, 1'b0);
      check("mid_rst_ret_data", ret_data, '0);
      check("mid_rst_araddr", araddr, 32'h0);
      b0 = beats;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("stale_beats", 32'(beats), 32'(b0));
      check("stale_arvalid", arvalid, 1'b0);
      rvalid = 1'b0;
      request(32'h0000_1000);
      serve(32'h0000_1000, 0, 1'b0, -1, -1, 32'h500);
      post_line(mk_line(32'h500), 1'b0, 10);

      // Early rlast on beat 5
      request(32'h1C00_0400);
      serve(32'h1C00_0400, 0, 1'b0, -1, 5, 32'h600);
      post_line(mk_line(32'h600), 1'b1, 10);

      // Request-lag filtering: rd_req held through DRAIN into IDLE
      request(32'h1C00_0200);
      serve(32'h1C00_0200, 0, 1'b0, -1, -1, 32'h700);
      rd_req  = 1'b1;
      rd_addr = 32'h1C00_0300;
      post_line(mk_line(32'h700), 1'b1, 10);
      @(negedge clk);
      check("lag_idle_arvalid", arvalid, 1'b0);
      start_req(32'h1C00_0300);
      @(negedge clk);
      rd_req = 1'b0;
      serve(32'h1C00_0300, 0, 1'b0, -1, -1, 32'h800);
      post_line(mk_line(32'h800), 1'b1, 10);

      // Line buffer: repeat request for the same line
      request(32'h1C00_0040);
      serve(32'h1C00_0040, 0, 1'b0, -1, -1, 32'h900);
      post_line(mk_line(32'h900), 1'b1, 10);
      request(32'h1C00_005C);
`ifdef ICACHE_REFILL_LINE_BUF_EN
      check("hit_ret_valid", ret_valid, 1'b1);
      check("hit_arvalid", arvalid, 1'b0);
      check("hit_ar_count", 32'(ar_cnt), 32'(ar_base));
      check("hit_latency", 32'(rv_cyc - req_cyc), 32'd1);
      check("hit_ret_data", ret_data, mk_line(32'h900));
      @(negedge clk);
      check("hit_pulse", ret_valid, 1'b0);
`else
      serve(32'h1C00_0040, 0, 1'b0, -1, -1, 32'h900);
      post_line(mk_line(32'h900), 1'b1, 10);
`endif
      request(32'h1C00_0060);
      serve(32'h1C00_0060, 0, 1'b0, -1, -1, 32'hA00);
      post_line(mk_line(32'hA00), 1'b1, 10);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/icache_refill_port.md
Name: icache_refill_port

Overview:
- Memory-side responder for the instruction cache's line-refill interface (rd_req/rd_addr in, ret_valid/ret_data out).
- Converts one refill request into a single AXI4 INCR burst read of LINE_WORDS 32-bit beats.
- Assembles the beats into one cache line and returns it with a one-cycle ret_valid pulse.
- Sits between the icache and the AXI read-channel arbiter/crossbar.

Parameters:
- LINE_WORDS, 8, 32-bit words per cache line; ret_data width = 32*LINE_WORDS; legal values 2, 4, 8, 16.
- ARID_VAL, 4'h0, constant driven on arid; also the rid value expected on returned beats.
- OFFSET_W, 5, byte-offset bits of a line, = log2(4*LINE_WORDS).

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rd_req  in  1  icache refill request; level, sampled only in IDLE.
- rd_addr  in  32  refill address; line-aligned internally.
- ret_valid  out  1  one-cycle pulse: ret_data holds the requested line.
- ret_data  out  32*LINE_WORDS  assembled line; word i at bits [32i+31:32i].
- arvalid  out  1  AXI AR valid.
- arready  in  1  AXI AR ready.
- araddr  out  32  burst address {rd_addr[31:OFFSET_W], OFFSET_W'b0}.
- arlen  out  8  LINE_WORDS-1.
- arsize  out  3  3'b010 (4 bytes per beat).
- arburst  out  2  2'b01 (INCR).
- arid  out  4  ARID_VAL.
- rvalid  in  1  AXI R valid.
- rready  out  1  AXI R ready.
- rdata  in  32  AXI R data.
- rresp  in  2  AXI R response.
- rlast  in  1  AXI R last beat.
- rid  in  4  AXI R id.
- bus_err  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (reset=0, takes effect asynchronously):
  - state=IDLE; arvalid=0, rready=0, ret_valid=0, bus_err=0.
  - ret_data=0, araddr=0, beat counter=0.
  - A reset asserted mid-burst abandons the burst; any later R beats are ignored because rready=0.
- arlen, arsize, arburst and arid are constants.
- IDLE:
  - If rd_req=1: latch the line-aligned address into araddr, set arvalid=1, go to AR. Takes 1 cycle.
  - If rd_req=0: stay in IDLE.
- AR:
  - Hold arvalid and araddr stable until arready=1.
  - On the arready=1 edge: arvalid=0, rready=1, cnt=0, go to R.
- R:
  - On each rvalid&rready: write rdata into word slot cnt of the line register, then cnt++.
  - rresp!=0 or rid!=ARID_VAL on any beat sets bus_err=1. The beat is still stored and the burst still completes.
  - Normal completion is the beat with cnt==LINE_WORDS-1. On that beat: rready=0, go to RESP.
  - rlast is checked on that final beat. rlast=0 on the final beat sets bus_err. rlast=1 on an earlier beat also sets bus_err, but the block keeps collecting until cnt reaches LINE_WORDS-1.
- RESP:
  - ret_valid=1 for exactly one cycle, with the line on ret_data; go to DRAIN.
  - ret_data holds its value until the next line completes.
- DRAIN:
  - 1 cycle; rd_req is ignored, to cover the icache's one-cycle lag in dropping its request; go to IDLE.
- Latency: with arready=1 in the AR cycle and rvalid=1 every cycle, the rd_req sample cycle to ret_valid is LINE_WORDS+2 cycles.
- A new request is accepted no earlier than 2 cycles after ret_valid.
- rd_addr changes after acceptance are ignored.
- rvalid is ignored in IDLE, AR, RESP and DRAIN (rready=0 in those states).

Optional Feature:
- Macro: ICACHE_REFILL_LINE_BUF_EN.
- Defined:
  - Keep the tag of the last successfully returned line (bits [31:OFFSET_W]) plus a valid bit.
  - The valid bit is cleared by reset, and by any burst that set bus_err.
  - An IDLE request whose tag matches the stored tag while valid=1 skips AR and R: go straight to RESP, and return the held ret_data with no AXI traffic (latency 1 cycle).
  - A mismatch behaves as the normal flow.
- Undefined: every request issues a burst; no tag or valid storage is built.

Test Plan:
- Basic line fetch (LINE_WORDS=8):
  - Stimulus: rd_req=1, rd_addr=32'h1C00_0044, arready=1 immediately, 8 back-to-back beats rdata=32'hA0+i, rlast on beat 7.
  - Required: araddr=32'h1C00_0040, arlen=7, arsize=2, arburst=1.
  - Required: ret_valid is high exactly once, 10 cycles after the rd_req sample; ret_data word i = 32'hA0+i; bus_err=0.
- Backpressure:
  - Stimulus: arready held 0 for 5 cycles; rvalid toggles 1,0,0,1,...
  - Required: arvalid and araddr stay stable until the handshake; ret_data is identical to the basic test; exactly one ret_valid.
- Error response:
  - Stimulus: rresp=2'b10 on beat 3.
  - Required: bus_err=1 from the cycle after beat 3 and stays 1; ret_valid still pulses after beat 7.
  - Stimulus: early rlast on beat 5.
  - Required: bus_err=1 and 8 beats are still consumed.
- Request-lag filtering:
  - Stimulus: hold rd_req=1 for 2 cycles after ret_valid.
  - Required: no second arvalid during DRAIN. A new AR appears only if rd_req is still 1 once the block is back in IDLE.
- Reset mid-burst:
  - Stimulus: assert reset (0) after beat 4, release it, then issue a new request to 32'h0000_1000.
  - Required: all outputs are 0 immediately; stale beats are not accepted; the new line returns correctly.
- ICACHE_REFILL_LINE_BUF_EN:
  - Stimulus: request 32'h1C00_0040, then 32'h1C00_005C.
  - Required: the second request causes no arvalid; ret_valid comes 1 cycle after the sample, with the same data.
  - Stimulus: request 32'h1C00_0060.
  - Required: a burst is issued.
